// File: rtl/sram_rw_init_ctrl_pkg.sv
// Shared types and default widths for the SRAM RW0-port front-end controller.
package sram_ctrl_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef enum logic {
        PRIO_WR,
        PRIO_RD
    } prio_e;

endpackage : sram_ctrl_pkg

// File: rtl/sram_rw_init_ctrl_if.sv
// Host-side read/write request channels and read response channel.
interface sram_rw_init_ctrl_if #(
    parameter int ADDR_W = sram_ctrl_pkg::DEF_ADDR_W,
    parameter int DATA_W = sram_ctrl_pkg::DEF_DATA_W
) ();

    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;

    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;
    logic [DATA_W-1:0] wr_req_mask;

    modport master (
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready, rd_resp_valid, rd_resp_data,
        output wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
        input  wr_req_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready, rd_resp_valid, rd_resp_data,
        input  wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
        output wr_req_ready
    );

endinterface : sram_rw_init_ctrl_if

// File: rtl/sram_rw_init_ctrl_arb.sv
// Read/write arbiter for the single RW0 port; on conflict the loser gets the next conflict.
module sram_rw_arb
    import sram_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic rd_valid,
    input  logic wr_valid,
    output logic rd_ready,
    output logic wr_ready,
    output logic gnt_rd,
    output logic gnt_wr
);

    prio_e prio_q, prio_d;

    // Each ready looks only at the other side's valid, never at its own.
    always_comb begin
        rd_ready = run && (!wr_valid || (prio_q == PRIO_RD));
        wr_ready = run && (!rd_valid || (prio_q == PRIO_WR));
        gnt_rd   = rd_ready && rd_valid;
        gnt_wr   = wr_ready && wr_valid;
        prio_d   = prio_q;
        if (run && rd_valid && wr_valid) begin
            prio_d = gnt_wr ? PRIO_RD : PRIO_WR;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= PRIO_WR;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule : sram_rw_arb

// File: rtl/sram_rw_init_ctrl.sv
// SRAM RW0-port front end: clears the array after reset, then arbitrates reads and
// masked writes onto the port and returns read data two cycles after acceptance.
module sram_rw_init_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                DEPTH         = 512,
    parameter int                ADDR_W        = DEF_ADDR_W,
    parameter int                DATA_W        = DEF_DATA_W,
    parameter bit                INIT_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                init_done,
    sram_rw_init_ctrl_if.slave  host,
    output logic                arr_en,
    output logic                arr_wmode,
    output logic [ADDR_W-1:0]   arr_addr,
    output logic [DATA_W-1:0]   arr_wmask,
    output logic [DATA_W-1:0]   arr_wdata,
    input  logic [DATA_W-1:0]   arr_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam state_e            RESET_STATE = INIT_ON_RESET ? INIT : RUN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_resp_valid_q, rd_resp_valid_d;
    logic [DATA_W-1:0] rd_resp_data_q, rd_resp_data_d;
    logic              rd_ready, wr_ready, gnt_rd, gnt_wr;

    sram_rw_arb u_arb (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (state_q == RUN),
        .rd_valid (host.rd_req_valid),
        .wr_valid (host.wr_req_valid),
        .rd_ready (rd_ready),
        .wr_ready (wr_ready),
        .gnt_rd   (gnt_rd),
        .gnt_wr   (gnt_wr)
    );

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        init_done_d     = init_done_q;
        arr_en          = 1'b0;
        arr_wmode       = 1'b0;
        arr_addr        = '0;
        arr_wmask       = '0;
        arr_wdata       = '0;
        rd_pend_d       = gnt_rd;
        rd_resp_valid_d = rd_pend_q;
        rd_resp_data_d  = rd_pend_q ? arr_rdata : rd_resp_data_q;

        case (state_q)
            INIT: begin
                arr_en     = 1'b1;
                arr_wmode  = 1'b1;
                arr_addr   = init_cnt_q;
                arr_wmask  = '1;
                arr_wdata  = INIT_VALUE;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (gnt_wr) begin
                    arr_en    = 1'b1;
                    arr_wmode = 1'b1;
                    arr_addr  = host.wr_req_addr;
                    arr_wmask = host.wr_req_mask;
                    arr_wdata = host.wr_req_data;
                end else if (gnt_rd) begin
                    arr_en   = 1'b1;
                    arr_addr = host.rd_req_addr;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= RESET_STATE;
            init_cnt_q      <= '0;
            init_done_q     <= !INIT_ON_RESET;
            rd_pend_q       <= 1'b0;
            rd_resp_valid_q <= 1'b0;
            rd_resp_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            init_cnt_q      <= init_cnt_d;
            init_done_q     <= init_done_d;
            rd_pend_q       <= rd_pend_d;
            rd_resp_valid_q <= rd_resp_valid_d;
            rd_resp_data_q  <= rd_resp_data_d;
        end
    end

    assign init_done          = init_done_q;
    assign host.rd_req_ready  = rd_ready;
    assign host.wr_req_ready  = wr_ready;
    assign host.rd_resp_valid = rd_resp_valid_q;
    assign host.rd_resp_data  = rd_resp_data_q;

endmodule : sram_rw_init_ctrl
